// File: rtl/regfile_if.sv
// Bus-side bundle for the register file: write port, reserve port and two read ports.
// The master drives requests; the slave (regfile) returns registered read data and busy flags.
interface regfile_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] bus;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic             selA;
    logic [AW-1:0]    raddr_a;
    logic             selB;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_busy;
    logic             b_busy;

    modport master (
        output we, waddr, bus, rsv, rsv_addr, selA, raddr_a, selB, raddr_b,
        input  a, b, a_busy, b_busy
    );

    modport slave (
        input  we, waddr, bus, rsv, rsv_addr, selA, raddr_a, selB, raddr_b,
        output a, b, a_busy, b_busy
    );
endinterface

// File: rtl/regfile_rdport.sv
// One registered read port: address decode, write/reserve bypass, zero-register
// handling, and the output data/busy registers.
module regfile_rdport #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ZERO_R0 = 0,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic [WIDTH-1:0] data,
    output logic             data_busy
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             busy_d, busy_q;
    logic             is_zero, hit_w, hit_r;

    assign is_zero = (ZERO_R0 != 0) && (raddr == '0);
    assign hit_w   = we && (waddr == raddr);
    assign hit_r   = rsv && (rsv_addr == raddr);

    // Busy reflects the post-edge scoreboard: a same-cycle reserve always wins.
    always_comb begin
        data_d = '0;
        busy_d = 1'b0;
        if (sel && !is_zero) begin
            if (hit_w) begin
                data_d = wdata;
                busy_d = hit_r;
            end else begin
                data_d = regs[raddr];
                busy_d = busy[raddr] | hit_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data      = data_q;
    assign data_busy = busy_q;
endmodule

// File: rtl/regfile.sv
// Parametrised register file with one write port, two registered read ports
// and a per-register busy scoreboard for reserving destinations.
module regfile #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  rf
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             wr_en, rsv_en;

    assign wr_en  = rf.we  && !((ZERO_R0 != 0) && (rf.waddr == '0));
    assign rsv_en = rf.rsv && !((ZERO_R0 != 0) && (rf.rsv_addr == '0));

    // Reserve is applied after the write-clear so a new producer keeps the slot busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)  busy_d[rf.waddr]    = 1'b0;
        if (rsv_en) busy_d[rf.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wr_en) mem_q[rf.waddr] <= rf.bus;
            busy_q <= busy_d;
        end
    end

    regfile_rdport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_R0 (ZERO_R0)
    ) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .sel       (rf.selA),
        .raddr     (rf.raddr_a),
        .regs      (mem_q),
        .busy      (busy_q),
        .we        (rf.we),
        .waddr     (rf.waddr),
        .wdata     (rf.bus),
        .rsv       (rf.rsv),
        .rsv_addr  (rf.rsv_addr),
        .data      (rf.a),
        .data_busy (rf.a_busy)
    );

    regfile_rdport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_R0 (ZERO_R0)
    ) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .sel       (rf.selB),
        .raddr     (rf.raddr_b),
        .regs      (mem_q),
        .busy      (busy_q),
        .we        (rf.we),
        .waddr     (rf.waddr),
        .wdata     (rf.bus),
        .rsv       (rf.rsv),
        .rsv_addr  (rf.rsv_addr),
        .data      (rf.b),
        .data_busy (rf.b_busy)
    );
endmodule
